// File: rtl/serial_rx_if.sv
// Byte-stream side of serial_rx: received data plus strobes and busy flag.
// parity_err exists only when SERIAL_RX_PARITY_EN is defined.
interface serial_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
`ifdef SERIAL_RX_PARITY_EN
  logic       parity_err;

  modport master (output rx_data, rx_valid, frame_err, rx_busy, parity_err);
  modport slave  (input  rx_data, rx_valid, frame_err, rx_busy, parity_err);
`else
  modport master (output rx_data, rx_valid, frame_err, rx_busy);
  modport slave  (input  rx_data, rx_valid, frame_err, rx_busy);
`endif
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framing check.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the parity_err strobe.
module serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        serial_in,
  serial_rx_if.master rx_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef SERIAL_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync_q, s_in_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_busy_q, rx_busy_d;
`ifdef SERIAL_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (!s_in_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Half-bit check rejects short low glitches as false starts.
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (s_in_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          shift_d   = {s_in_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          par_bit_d = s_in_q;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          rx_data_d = 8'(shift_q);
          if (s_in_q) begin
            state_d = StIdle;
`ifdef SERIAL_RX_PARITY_EN
            if ((^shift_q) ^ par_bit_q) begin
              parity_err_d = 1'b1;
            end else begin
              rx_valid_d = 1'b1;
            end
`else
            rx_valid_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A held-low break must not be read as a string of zero bytes.
        if (s_in_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    rx_busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q      <= 1'b1;
      s_in_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= serial_in;
      s_in_q      <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
`ifdef SERIAL_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = rx_busy_q;
`ifdef SERIAL_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`endif

endmodule
